// File: rtl/video_timing_pkg.sv
// Shared timing definitions for the video timing generator and its config sequencer.
package video_timing_pkg;

  localparam int unsigned TIMING_W = 12;
  localparam int unsigned CFG_W    = 32;

  localparam logic [TIMING_W-1:0] H_ACTIVE_DEFAULT     = 12'd1280;
  localparam logic [TIMING_W-1:0] V_ACTIVE_DEFAULT     = 12'd720;
  localparam logic [TIMING_W-1:0] H_TOTAL_DEFAULT      = 12'd1650;
  localparam logic [TIMING_W-1:0] V_TOTAL_DEFAULT      = 12'd750;
  localparam logic [TIMING_W-1:0] H_SYNC_START_DEFAULT = 12'd1390;
  localparam logic [TIMING_W-1:0] H_SYNC_END_DEFAULT   = 12'd1430;
  localparam logic [TIMING_W-1:0] V_SYNC_START_DEFAULT = 12'd725;
  localparam logic [TIMING_W-1:0] V_SYNC_END_DEFAULT   = 12'd730;

  typedef enum logic [1:0] {OFF, RESTART, RUN, PENDING} state_e;

  typedef struct packed {
    logic [TIMING_W-1:0] h_active;
    logic [TIMING_W-1:0] v_active;
    logic [TIMING_W-1:0] h_total;
    logic [TIMING_W-1:0] v_total;
    logic [TIMING_W-1:0] h_sync_start;
    logic [TIMING_W-1:0] h_sync_end;
    logic [TIMING_W-1:0] v_sync_start;
    logic [TIMING_W-1:0] v_sync_end;
  } timing_t;

  localparam timing_t TIMING_DEFAULT = '{
    h_active:     H_ACTIVE_DEFAULT,
    v_active:     V_ACTIVE_DEFAULT,
    h_total:      H_TOTAL_DEFAULT,
    v_total:      V_TOTAL_DEFAULT,
    h_sync_start: H_SYNC_START_DEFAULT,
    h_sync_end:   H_SYNC_END_DEFAULT,
    v_sync_start: V_SYNC_START_DEFAULT,
    v_sync_end:   V_SYNC_END_DEFAULT
  };

  // A zero register field means "use the built-in default".
  function automatic logic [TIMING_W-1:0] pick_field(input logic [CFG_W-1:0] raw,
                                                     input logic [TIMING_W-1:0] dflt);
    return (raw == '0) ? dflt : raw[TIMING_W-1:0];
  endfunction

  function automatic logic fits_field(input logic [CFG_W-1:0] raw);
    return (raw[CFG_W-1:TIMING_W] == '0);
  endfunction

endpackage

// File: rtl/video_timing_config_sequencer_if.sv
// Register-file / generator facing signals of the timing config sequencer.
interface video_timing_config_sequencer_if #(
  parameter int unsigned FRAME_CNT_W = 16
);
  import video_timing_pkg::*;

  logic                   enable;
  logic                   cfg_commit;
  logic                   err_clr;
  logic [CFG_W-1:0]       cfg_h_active;
  logic [CFG_W-1:0]       cfg_v_active;
  logic [CFG_W-1:0]       cfg_h_total;
  logic [CFG_W-1:0]       cfg_v_total;
  logic [CFG_W-1:0]       cfg_h_sync_start;
  logic [CFG_W-1:0]       cfg_h_sync_end;
  logic [CFG_W-1:0]       cfg_v_sync_start;
  logic [CFG_W-1:0]       cfg_v_sync_end;
  logic                   vsync_in;

  logic [CFG_W-1:0]       h_active_out;
  logic [CFG_W-1:0]       v_active_out;
  logic [CFG_W-1:0]       h_total_out;
  logic [CFG_W-1:0]       v_total_out;
  logic [CFG_W-1:0]       h_sync_start_out;
  logic [CFG_W-1:0]       h_sync_end_out;
  logic [CFG_W-1:0]       v_sync_start_out;
  logic [CFG_W-1:0]       v_sync_end_out;
  logic                   vtg_rst_n;
  logic                   cfg_busy;
  logic                   cfg_applied;
  logic                   cfg_error;
  logic [FRAME_CNT_W-1:0] frame_count;

  modport master (
    output enable, cfg_commit, err_clr,
    output cfg_h_active, cfg_v_active, cfg_h_total, cfg_v_total,
    output cfg_h_sync_start, cfg_h_sync_end, cfg_v_sync_start, cfg_v_sync_end,
    output vsync_in,
    input  h_active_out, v_active_out, h_total_out, v_total_out,
    input  h_sync_start_out, h_sync_end_out, v_sync_start_out, v_sync_end_out,
    input  vtg_rst_n, cfg_busy, cfg_applied, cfg_error, frame_count
  );

  modport slave (
    input  enable, cfg_commit, err_clr,
    input  cfg_h_active, cfg_v_active, cfg_h_total, cfg_v_total,
    input  cfg_h_sync_start, cfg_h_sync_end, cfg_v_sync_start, cfg_v_sync_end,
    input  vsync_in,
    output h_active_out, v_active_out, h_total_out, v_total_out,
    output h_sync_start_out, h_sync_end_out, v_sync_start_out, v_sync_end_out,
    output vtg_rst_n, cfg_busy, cfg_applied, cfg_error, frame_count
  );

endinterface

// File: rtl/video_timing_cfg_check.sv
// Resolves zero fields to defaults and checks the staged timing set for consistency.
module video_timing_cfg_check
  import video_timing_pkg::*;
(
  input  logic [CFG_W-1:0] h_active_i,
  input  logic [CFG_W-1:0] v_active_i,
  input  logic [CFG_W-1:0] h_total_i,
  input  logic [CFG_W-1:0] v_total_i,
  input  logic [CFG_W-1:0] h_sync_start_i,
  input  logic [CFG_W-1:0] h_sync_end_i,
  input  logic [CFG_W-1:0] v_sync_start_i,
  input  logic [CFG_W-1:0] v_sync_end_i,
  output timing_t          timing_c_o,
  output logic             valid_c_o
);

  logic fits_c;
  logic h_order_c;
  logic v_order_c;

  always_comb begin
    timing_c_o.h_active     = pick_field(h_active_i,     H_ACTIVE_DEFAULT);
    timing_c_o.v_active     = pick_field(v_active_i,     V_ACTIVE_DEFAULT);
    timing_c_o.h_total      = pick_field(h_total_i,      H_TOTAL_DEFAULT);
    timing_c_o.v_total      = pick_field(v_total_i,      V_TOTAL_DEFAULT);
    timing_c_o.h_sync_start = pick_field(h_sync_start_i, H_SYNC_START_DEFAULT);
    timing_c_o.h_sync_end   = pick_field(h_sync_end_i,   H_SYNC_END_DEFAULT);
    timing_c_o.v_sync_start = pick_field(v_sync_start_i, V_SYNC_START_DEFAULT);
    timing_c_o.v_sync_end   = pick_field(v_sync_end_i,   V_SYNC_END_DEFAULT);

    fits_c = fits_field(h_active_i)     & fits_field(v_active_i) &
             fits_field(h_total_i)      & fits_field(v_total_i) &
             fits_field(h_sync_start_i) & fits_field(h_sync_end_i) &
             fits_field(v_sync_start_i) & fits_field(v_sync_end_i);

    // Sync pulse must sit strictly after active video and end within the line/frame.
    h_order_c = (timing_c_o.h_active < timing_c_o.h_sync_start) &
                (timing_c_o.h_sync_start < timing_c_o.h_sync_end) &
                (timing_c_o.h_sync_end <= timing_c_o.h_total);
    v_order_c = (timing_c_o.v_active < timing_c_o.v_sync_start) &
                (timing_c_o.v_sync_start < timing_c_o.v_sync_end) &
                (timing_c_o.v_sync_end <= timing_c_o.v_total);

    valid_c_o = fits_c & h_order_c & v_order_c;
  end

endmodule

// File: rtl/video_timing_config_sequencer.sv
// Sequences generator reset and applies committed timing sets only at frame boundaries.
module video_timing_config_sequencer
  import video_timing_pkg::*;
#(
  parameter int unsigned RESTART_CYCLES = 16,
  parameter int unsigned FRAME_CNT_W    = 16
) (
  input  logic                            pixel_clk,
  input  logic                            rst,
  video_timing_config_sequencer_if.slave  seq_if
);

  localparam int unsigned        CNT_W        = 8;
  localparam logic [CNT_W-1:0]   RESTART_LOAD = CNT_W'(RESTART_CYCLES - 1);

  timing_t                chk_timing;
  logic                   chk_valid;
  logic                   commit_ok;
  logic                   commit_bad;
  logic                   vs_edge;

  state_e                 state_q;
  logic [CNT_W-1:0]       restart_cnt_q;
  timing_t                active_q;
  timing_t                pending_q;
  logic                   vsync_q;
  logic                   vtg_rst_n_q;
  logic                   busy_q;
  logic                   applied_q;
  logic                   error_q;
  logic [FRAME_CNT_W-1:0] frame_q;

  video_timing_cfg_check u_check (
    .h_active_i     (seq_if.cfg_h_active),
    .v_active_i     (seq_if.cfg_v_active),
    .h_total_i      (seq_if.cfg_h_total),
    .v_total_i      (seq_if.cfg_v_total),
    .h_sync_start_i (seq_if.cfg_h_sync_start),
    .h_sync_end_i   (seq_if.cfg_h_sync_end),
    .v_sync_start_i (seq_if.cfg_v_sync_start),
    .v_sync_end_i   (seq_if.cfg_v_sync_end),
    .timing_c_o     (chk_timing),
    .valid_c_o      (chk_valid)
  );

  assign commit_ok  = seq_if.cfg_commit & chk_valid;
  assign commit_bad = seq_if.cfg_commit & ~chk_valid;
  assign vs_edge    = vsync_q & ~seq_if.vsync_in;

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      state_q       <= OFF;
      restart_cnt_q <= '0;
      active_q      <= TIMING_DEFAULT;
      pending_q     <= TIMING_DEFAULT;
      vsync_q       <= 1'b1;
      vtg_rst_n_q   <= 1'b0;
      busy_q        <= 1'b0;
      applied_q     <= 1'b0;
      error_q       <= 1'b0;
      frame_q       <= '0;
    end else begin
      vsync_q   <= seq_if.vsync_in;
      applied_q <= 1'b0;

      // A rejected commit wins over a simultaneous clear.
      if (commit_bad)          error_q <= 1'b1;
      else if (seq_if.err_clr) error_q <= 1'b0;

      if (((state_q == RUN) || (state_q == PENDING)) && vs_edge)
        frame_q <= frame_q + FRAME_CNT_W'(1);

      unique case (state_q)
        OFF: begin
          if (commit_ok) active_q <= chk_timing;
          if (seq_if.enable) begin
            state_q       <= RESTART;
            restart_cnt_q <= RESTART_LOAD;
            frame_q       <= '0;
          end
        end
        RESTART: begin
          // Generator is still in reset, so a new set can go live directly.
          if (commit_ok) active_q <= chk_timing;
          if (!seq_if.enable) begin
            state_q <= OFF;
          end else if (restart_cnt_q == '0) begin
            state_q     <= RUN;
            vtg_rst_n_q <= 1'b1;
          end else begin
            restart_cnt_q <= restart_cnt_q - CNT_W'(1);
          end
        end
        RUN: begin
          if (!seq_if.enable) begin
            state_q     <= OFF;
            vtg_rst_n_q <= 1'b0;
            if (commit_ok) active_q <= chk_timing;
          end else if (commit_ok) begin
            pending_q <= chk_timing;
            busy_q    <= 1'b1;
            state_q   <= PENDING;
          end
        end
        PENDING: begin
          if (!seq_if.enable) begin
            state_q     <= OFF;
            vtg_rst_n_q <= 1'b0;
            busy_q      <= 1'b0;
            active_q    <= commit_ok ? chk_timing : pending_q;
          end else begin
            if (vs_edge) begin
              active_q  <= pending_q;
              applied_q <= 1'b1;
            end
            // A same-cycle commit becomes the next pending set; otherwise drain on the edge.
            if (commit_ok) begin
              pending_q <= chk_timing;
            end else if (vs_edge) begin
              busy_q  <= 1'b0;
              state_q <= RUN;
            end
          end
        end
        default: state_q <= OFF;
      endcase
    end
  end

  assign seq_if.h_active_out     = CFG_W'(active_q.h_active);
  assign seq_if.v_active_out     = CFG_W'(active_q.v_active);
  assign seq_if.h_total_out      = CFG_W'(active_q.h_total);
  assign seq_if.v_total_out      = CFG_W'(active_q.v_total);
  assign seq_if.h_sync_start_out = CFG_W'(active_q.h_sync_start);
  assign seq_if.h_sync_end_out   = CFG_W'(active_q.h_sync_end);
  assign seq_if.v_sync_start_out = CFG_W'(active_q.v_sync_start);
  assign seq_if.v_sync_end_out   = CFG_W'(active_q.v_sync_end);
  assign seq_if.vtg_rst_n        = vtg_rst_n_q;
  assign seq_if.cfg_busy         = busy_q;
  assign seq_if.cfg_applied      = applied_q;
  assign seq_if.cfg_error        = error_q;
  assign seq_if.frame_count      = frame_q;

endmodule
